// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and helpers
//
// Imported by the receive core and its sampler; the transmit side reuses it.
package uart_pkg;

    // FSM state encoding (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity modes
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, edge detect, tick counter, mid-bit vote
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   sample_tick_i     one-clk pulse at OVERSAMPLE x baud
//   rx_i              raw serial line (asynchronous)
//   clr_i             clears the tick counter (core asserts on every state change)
//   rxs_o             synchronised line
//   fall_o            1->0 transition on rxs_o
//   bit_val_o         majority of the samples at ticks M-1, M, M+1
//   bit_strobe_o      vote point (tick M+1); bit_val_o is valid here
//   bit_end_o         last tick of the bit period (tick OVERSAMPLE-1)
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick_i,
    input  logic rx_i,
    input  logic clr_i,
    output logic rxs_o,
    output logic fall_o,
    output logic bit_val_o,
    output logic bit_strobe_o,
    output logic bit_end_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_A   = TW'(M - 1);
    localparam logic [TW-1:0] T_B   = TW'(M);
    localparam logic [TW-1:0] T_V   = TW'(M + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    logic          sync1_q, sync2_q, prev_q;
    logic          samp_a_q, samp_b_q;
    logic [TW-1:0] tcnt_q, tcnt_d;

    // Counter wraps at the bit end so consecutive bits in one state stay aligned
    always_comb begin
        tcnt_d = tcnt_q;
        if (clr_i) begin
            tcnt_d = '0;
        end else if (sample_tick_i) begin
            tcnt_d = (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
            tcnt_q   <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tcnt_q  <= tcnt_d;
            if (sample_tick_i && (tcnt_q == T_A)) begin
                samp_a_q <= sync2_q;
            end
            if (sample_tick_i && (tcnt_q == T_B)) begin
                samp_b_q <= sync2_q;
            end
        end
    end

    assign rxs_o        = sync2_q;
    assign fall_o       = prev_q & ~sync2_q;
    // Third sample is taken live at the vote tick
    assign bit_val_o    = maj3(samp_a_q, samp_b_q, sync2_q);
    assign bit_strobe_o = sample_tick_i && (tcnt_q == T_V);
    assign bit_end_o    = sample_tick_i && (tcnt_q == T_END);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised UART receiver with valid/ready output and sticky errors
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   sample_tick    one-clk pulse at OVERSAMPLE x baud
//   rx             raw serial line, idle high
//   rx_data        received word, stable while rx_valid
//   rx_valid       word available; rx_ready accepts it
//   parity_err     sticky parity mismatch
//   frame_err      sticky low stop bit
//   overrun_err    sticky word dropped because previous word not yet taken
//   err_clr        clears the sticky flags (a same-cycle set wins)
//   busy           FSM not idle
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int   BW    = $clog2(DATA_BITS + 1);
    localparam logic P_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic                 par_pend_q, par_pend_d;
    logic                 frm_pend_q, frm_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;
    logic                 complete;

    logic rxs, fall, bit_val, bit_strobe, bit_end, state_chg;

    assign state_chg = (state_d != state_q);

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .sample_tick_i(sample_tick),
        .rx_i         (rx),
        .clr_i        (state_chg),
        .rxs_o        (rxs),
        .fall_o       (fall),
        .bit_val_o    (bit_val),
        .bit_strobe_o (bit_strobe),
        .bit_end_o    (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        sr_d       = sr_q;
        par_pend_d = par_pend_q;
        frm_pend_d = frm_pend_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        oerr_d     = oerr_q;
        complete   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall && !rxs) begin
                    state_d    = ST_START;
                    bcnt_d     = '0;
                    par_pend_d = 1'b0;
                    frm_pend_d = 1'b0;
                end
            end
            ST_START: begin
                // A start bit that votes high was noise
                if (bit_strobe && bit_val) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    sr_d = {bit_val, sr_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bcnt_q == LAST_DATA) begin
                        bcnt_d  = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_strobe && (bit_val != ((^sr_q) ^ P_SEL))) begin
                    par_pend_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    if (!bit_val) begin
                        frm_pend_d = 1'b1;
                    end
                    // Finish at the last vote so a following start edge is not missed
                    if (bcnt_q == LAST_STOP) begin
                        complete = 1'b1;
                        bcnt_d   = '0;
                        state_d  = ST_IDLE;
                    end
                end else if (bit_end) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (err_clr) begin
            perr_d = 1'b0;
            ferr_d = 1'b0;
            oerr_d = 1'b0;
        end

        // Applied after err_clr so a same-cycle set wins
        if (complete) begin
            perr_d = perr_d | par_pend_q;
            ferr_d = ferr_d | frm_pend_d;
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = sr_q;
                rx_valid_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bcnt_q     <= '0;
            sr_q       <= '0;
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            sr_q       <= sr_d;
            par_pend_q <= par_pend_d;
            frm_pend_q <= frm_pend_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            oerr_q     <= oerr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;

    localparam int BITC = 64;  // clocks per bit: 16 ticks x 4 clocks

    logic       clk = 1'b0;
    logic [1:0] tick_cnt = 2'd0;
    logic       sample_tick;

    always #5 clk = ~clk;
    always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
    assign sample_tick = (tick_cnt == 2'd3);

    // 8E1 instance
    logic       reset1, rx1, rx_ready1, err_clr1;
    logic [7:0] rx_data1;
    logic       rx_valid1, parity_err1, frame_err1, overrun_err1, busy1;

    uart_rx_core #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .reset(reset1), .sample_tick(sample_tick), .rx(rx1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .parity_err(parity_err1), .frame_err(frame_err1), .overrun_err(overrun_err1),
        .err_clr(err_clr1), .busy(busy1)
    );

    // 9N2 instance
    logic       reset2, rx2, rx_ready2, err_clr2;
    logic [8:0] rx_data2;
    logic       rx_valid2, parity_err2, frame_err2, overrun_err2, busy2;

    uart_rx_core #(
        .DATA_BITS(9), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .reset(reset2), .sample_tick(sample_tick), .rx(rx2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
        .parity_err(parity_err2), .frame_err(frame_err2), .overrun_err(overrun_err2),
        .err_clr(err_clr2), .busy(busy2)
    );

    // Valid-cycle counters and last word seen on each instance
    int         vcnt1 = 0, vcnt2 = 0;
    logic [7:0] last1 = '0;
    logic [8:0] last2 = '0;

    always @(negedge clk) begin
        if (rx_valid1) begin
            vcnt1 <= vcnt1 + 1;
            last1 <= rx_data1;
        end
        if (rx_valid2) begin
            vcnt2 <= vcnt2 + 1;
            last2 <= rx_data2;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bit1(input logic b);
        rx1 = b;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic bit2(input logic b);
        rx2 = b;
        repeat (BITC) @(negedge clk);
    endtask

    // start, 8 data LSB first, parity (optionally inverted), stop
    task automatic frame8(input logic [7:0] d, input logic pflip, input logic stop);
        bit1(1'b0);
        for (int i = 0; i < 8; i++) bit1(d[i]);
        bit1((^d) ^ pflip);
        bit1(stop);
    endtask

    task automatic pulse_clr1();
        err_clr1 = 1'b1;
        @(negedge clk);
        err_clr1 = 1'b0;
        @(negedge clk);
    endtask

    int         v0;
    logic [8:0] w9;

    initial begin
        reset1 = 1'b0; rx1 = 1'b1; rx_ready1 = 1'b1; err_clr1 = 1'b0;
        reset2 = 1'b0; rx2 = 1'b1; rx_ready2 = 1'b1; err_clr2 = 1'b0;
        repeat (5) @(negedge clk);

        chk("rst_data",    16'(rx_data1),     16'h0000);
        chk("rst_valid",   16'(rx_valid1),    16'h0000);
        chk("rst_perr",    16'(parity_err1),  16'h0000);
        chk("rst_ferr",    16'(frame_err1),   16'h0000);
        chk("rst_oerr",    16'(overrun_err1), 16'h0000);
        chk("rst_busy",    16'(busy1),        16'h0000);

        reset1 = 1'b1;
        reset2 = 1'b1;
        repeat (BITC) @(negedge clk);

        // 0xA5, even parity bit 0
        v0 = vcnt1;
        frame8(8'hA5, 1'b0, 1'b1);
        bit1(1'b1);
        chk("a5_pulse",    16'(vcnt1 - v0),   16'd1);
        chk("a5_data",     16'(last1),        16'h00A5);
        chk("a5_perr",     16'(parity_err1),  16'h0000);
        chk("a5_ferr",     16'(frame_err1),   16'h0000);
        chk("a5_oerr",     16'(overrun_err1), 16'h0000);
        chk("a5_busy",     16'(busy1),        16'h0000);

        // 0x3C with inverted parity
        frame8(8'h3C, 1'b1, 1'b1);
        bit1(1'b1);
        chk("3c_data",     16'(last1),        16'h003C);
        chk("3c_perr",     16'(parity_err1),  16'h0001);
        chk("3c_ferr",     16'(frame_err1),   16'h0000);
        pulse_clr1();
        chk("3c_clr",      16'(parity_err1),  16'h0000);

        // 0x55 with low stop bit
        frame8(8'h55, 1'b0, 1'b0);
        bit1(1'b1);
        chk("55_data",     16'(last1),        16'h0055);
        chk("55_ferr",     16'(frame_err1),   16'h0001);
        chk("55_perr",     16'(parity_err1),  16'h0000);
        chk("55_busy",     16'(busy1),        16'h0000);
        pulse_clr1();
        chk("55_clr",      16'(frame_err1),   16'h0000);

        // next frame still received cleanly
        frame8(8'h81, 1'b0, 1'b1);
        bit1(1'b1);
        chk("81_data",     16'(last1),        16'h0081);
        chk("81_ferr",     16'(frame_err1),   16'h0000);

        // overrun: two back-to-back frames with consumer stalled
        rx_ready1 = 1'b0;
        frame8(8'h11, 1'b0, 1'b1);
        frame8(8'h22, 1'b0, 1'b1);
        bit1(1'b1);
        chk("ovr_data",    16'(rx_data1),     16'h0011);
        chk("ovr_valid",   16'(rx_valid1),    16'h0001);
        chk("ovr_oerr",    16'(overrun_err1), 16'h0001);
        chk("ovr_perr",    16'(parity_err1),  16'h0000);
        rx_ready1 = 1'b1;
        @(negedge clk);
        chk("ovr_drop",    16'(rx_valid1),    16'h0000);
        chk("ovr_sticky",  16'(overrun_err1), 16'h0001);

        // 4-tick low glitch while idle
        v0 = vcnt1;
        rx1 = 1'b0;
        repeat (16) @(negedge clk);
        rx1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("gl_busy_hi",  16'(busy1),        16'h0001);
        repeat (BITC) @(negedge clk);
        chk("gl_busy_lo",  16'(busy1),        16'h0000);
        chk("gl_valid",    16'(vcnt1 - v0),   16'd0);
        chk("gl_oerr",     16'(overrun_err1), 16'h0001);
        pulse_clr1();
        chk("gl_clr",      16'(overrun_err1), 16'h0000);

        // 9N2: 0x1F3
        w9 = 9'h1F3;
        v0 = vcnt2;
        bit2(1'b0);
        for (int i = 0; i < 9; i++) bit2(w9[i]);
        bit2(1'b1);
        bit2(1'b1);
        bit2(1'b1);
        chk("n2_pulse",    16'(vcnt2 - v0),   16'd1);
        chk("n2_data",     16'(last2),        16'h01F3);
        chk("n2_ferr",     16'(frame_err2),   16'h0000);
        chk("n2_busy",     16'(busy2),        16'h0000);

        // reset in the middle of DATA
        bit2(1'b0);
        bit2(1'b1);
        bit2(1'b0);
        rx2 = 1'b1;
        repeat (BITC / 2) @(negedge clk);
        chk("mid_busy",    16'(busy2),        16'h0001);
        reset2 = 1'b0;
        #1;
        chk("mr_busy",     16'(busy2),        16'h0000);
        chk("mr_valid",    16'(rx_valid2),    16'h0000);
        chk("mr_data",     16'(rx_data2),     16'h0000);
        chk("mr_ferr",     16'(frame_err2),   16'h0000);
        chk("mr_oerr",     16'(overrun_err2), 16'h0000);
        @(negedge clk);
        reset2 = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_idle",     16'(busy2),        16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receiver that replaces the fixed 8-bit receive controller with a complete, self-timed receive path. It synchronises the serial line, detects the start bit, and recovers each bit by majority vote at mid-bit. It checks optional parity and 1 or 2 stop bits, then presents each word on a valid/ready output with sticky error flags. It sits between the baud tick generator and the RX FIFO / host register block.

Parameters:
DATA_BITS, 8, word width, legal 5..9, LSB received first
OVERSAMPLE, 16, sample_tick pulses per bit period, legal even values 8..32
PARITY_EN, 1, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, stop bits checked, legal 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (assert low, release synchronous to clk)
sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rx  input  1  raw serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received word, stable while rx_valid=1
rx_valid  output  1  word available
rx_ready  input  1  consumer accepts word when rx_valid && rx_ready
parity_err  output  1  sticky, parity mismatch seen
frame_err  output  1  sticky, a stop bit sampled low
overrun_err  output  1  sticky, word completed while rx_valid=1 and not yet accepted
err_clr  input  1  one-clk pulse, clears all three sticky flags
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low): state=IDLE; rx_data=0; rx_valid=0; all error flags=0; busy=0; tick counter=0; bit counter=0; synchroniser flops=1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Tick counter tcnt counts sample_tick pulses only; it is cleared on every state change. Sample points are ticks M-1, M and M+1, with M=OVERSAMPLE/2. The bit value is the majority of the 3 samples, registered at tick M+1.
- IDLE: a falling edge on rxs (prev 1, now 1->0) moves to START.
- START: at the vote point, bit=1 -> false start, back to IDLE, no flags touched. Bit=0 -> continue to tick OVERSAMPLE-1, then go to DATA.
- DATA: one bit per OVERSAMPLE ticks, voted bit shifted in at the MSB of a DATA_BITS shift register (LSB first). After DATA_BITS bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: the voted bit is compared with XOR(data) XOR PARITY_ODD. On mismatch, latch a pending parity fault. The frame always continues to STOP; there is no early abort.
- STOP: STOP_BITS bits are sampled. Any low stop bit latches a pending frame fault.
  - For the last stop bit, completion occurs at the vote point (tick M+1), not at the bit end, so back-to-back frames are caught.
  - On completion the state returns to IDLE.
- Completion in the same cycle as the transition to IDLE:
  - If rx_valid=0 or (rx_valid && rx_ready): rx_data <= shift register, rx_valid <= 1. parity_err and frame_err are OR-ed with the pending faults.
  - If rx_valid=1 and rx_ready=0: the new word is dropped, rx_data is unchanged, overrun_err <= 1. Pending parity/frame faults are still OR-ed into the flags.
  - Words with parity or frame faults are still delivered; the flags mark them.
- Handshake: rx_valid clears on the cycle after rx_valid && rx_ready, unless a completion loads a new word in that same cycle, in which case rx_valid stays 1. rx_ready is ignored while rx_valid=0.
- Sticky flags hold until err_clr. If err_clr and a new error set occur in the same cycle, set wins.
- reset asserted mid-frame: immediate return to the reset values; the partial word is discarded.
- sample_tick low for long periods is legal; the FSM simply waits.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: ST_IDLE=0, ST_START=1, ST_DATA=2, ST_PARITY=3, ST_STOP=4 (3-bit);
  - parity-mode constants PAR_EVEN=0, PAR_ODD=1.
  - The TX-side successor will reuse this package.
- One sub-module, uart_rx_sampler: synchroniser, falling-edge detect, tick counter and 3-sample majority vote. Outputs are rxs, fall, bit_val and bit_strobe (the vote point) plus bit_end (tick OVERSAMPLE-1). The FSM, shift register, parity and output handshake stay in uart_rx_core.

Test Plan:
- Defaults (8E1, OVERSAMPLE=16); send 0xA5 with even parity bit 0; rx_ready=1 -> rx_valid pulses one cycle after the stop vote with rx_data=0xA5, all error flags 0.
- Send 0x3C with the parity bit inverted -> rx_data=0x3C delivered and parity_err=1. Pulse err_clr -> parity_err=0.
- Send 0x55 with the stop bit driven low -> frame_err=1, rx_data=0x55, FSM back in IDLE ready for the next frame.
- rx_ready=0; send 0x11 then 0x22 back to back -> rx_data remains 0x11 and overrun_err=1. Raise rx_ready -> rx_valid drops the next cycle.
- Low glitch on rx of 4 sample periods while idle -> false start, rx_valid stays 0, busy returns to 0.
- DATA_BITS=9, PARITY_EN=0, STOP_BITS=2; send 0x1F3 -> rx_data=0x1F3. Assert reset low mid-DATA -> all outputs return to 0 and busy=0 on the same cycle.
